hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 16-bit five-stage pipeline.
- Watches ID-stage source registers, the EX-stage destination, load and branch status, and multi-cycle mul/div starts.
- Drives write-enables and bubble/flush controls for PC, IF/ID, ID/EX, the EX unit and the EX/MEM register. It is the only block that sequences those pipeline registers.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REGW, 4, register-index width.
- MC_CYCLES, 4, EX hold cycles for a mul/div op. Legal range 1..15.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- idRegOp1  in  REGW  source reg 1 of instruction in ID.
- idRegOp2  in  REGW  source reg 2 of instruction in ID.
- idUsesOp1  in  1  ID instruction reads idRegOp1.
- idUsesOp2  in  1  ID instruction reads idRegOp2.
- exRegDst  in  REGW  destination reg of instruction in EX.
- exMemRead  in  1  EX instruction is a load.
- exWB  in  1  EX instruction writes back.
- exMulDiv  in  1  mul/div entering EX this cycle; one-cycle pulse.
- branchTaken  in  1  branch resolved taken in EX.
- pcWrite  out  1  PC update enable.
- ifIdWrite  out  1  IF/ID register enable.
- ifIdFlush  out  1  clear IF/ID to NOP.
- idExBubble  out  1  load NOP into ID/EX (wb=0, mem=0).
- exHold  out  1  freeze EX operands; mul/div unit busy.
- exMemBubble  out  1  force wb=0 into EX/MEM.
- state  out  1  0=RUN, 1=MC_BUSY.
- stallCount  out  16  cycles with pcWrite=0, saturating.

Behaviour:
- Registered state: FSM state, 4-bit busy counter mcCnt, stallCount. All control outputs are combinational from state, mcCnt, inputs and rst.
- rst low (sampled at edge): next state RUN, mcCnt=0, stallCount=0.
  - While rst is low, outputs are forced to pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExBubble=1, exHold=0, exMemBubble=1.
  - Reset mid-MC_BUSY aborts the op; no release cycle is produced.
  - stallCount does not count reset cycles.
- Load-use hazard: loadUse = exMemRead & exWB & ((idUsesOp1 & idRegOp1==exRegDst) | (idUsesOp2 & idRegOp2==exRegDst)). Register 0 gets no special treatment.
- Default (RUN, nothing active): pcWrite=1, ifIdWrite=1, all other controls 0.
- RUN priority (highest first): branchTaken > exMulDiv > loadUse.
  - branchTaken: ifIdFlush=1, idExBubble=1, pcWrite=1, ifIdWrite=1. Next state RUN. A simultaneous exMulDiv or loadUse is ignored, because the flushed instruction is squashed.
  - exMulDiv: pcWrite=0, ifIdWrite=0, exHold=1, exMemBubble=1. Next state MC_BUSY, mcCnt <= MC_CYCLES-1.
  - loadUse: pcWrite=0, ifIdWrite=0, idExBubble=1. Next state RUN. The stall lasts one cycle, since the load moves to MEM and the hazard clears.
- MC_BUSY, mcCnt != 0:
  - pcWrite=0, ifIdWrite=0, exHold=1, exMemBubble=1.
  - mcCnt decrements each cycle.
  - branchTaken, exMulDiv and loadUse are all ignored.
- MC_BUSY, mcCnt == 0 (release cycle):
  - exHold=0, exMemBubble=0, pcWrite=1, ifIdWrite=1.
  - The result passes into EX/MEM. Next state RUN.
- Latency:
  - exMulDiv pulse to release cycle = MC_CYCLES cycles. Stall cycles = MC_CYCLES.
  - MC_CYCLES=1: entry cycle stalls, the next cycle is the release.
- stallCount increments on each clock edge where rst=1 and pcWrite=0. It holds at 16'hFFFF.

Test Plan:
- Reset with rst=0 for 2 cycles -> pcWrite=0, ifIdFlush=1, idExBubble=1, exMemBubble=1, stallCount=0, state=0. After release with idle inputs -> pcWrite=1, all other controls 0.
- exMemRead=1, exWB=1, exRegDst=5, idRegOp2=5, idUsesOp2=1 -> exactly one cycle of pcWrite=0, ifIdWrite=0, idExBubble=1; stallCount=1. Same stimulus with idUsesOp2=0 or exWB=0 -> no stall.
- MC_CYCLES=4, exMulDiv pulse at cycle t -> pcWrite=0 and exHold=1 in cycles t..t+3; release at t+4 with exHold=0, exMemBubble=0, pcWrite=1; state 1 for t+1..t+4; stallCount=4.
- branchTaken=1 together with exMulDiv=1 and a loadUse match -> ifIdFlush=1, idExBubble=1, pcWrite=1, exHold=0; state stays 0.
- exMulDiv at t, rst=0 at t+2 -> from t+3 state=0 and mcCnt=0, no release cycle, stallCount=0. After rst=1, a loadUse counts from 1.
- MC_CYCLES=1 build: exMulDiv pulse -> one stall cycle, then release; a second pulse during the release cycle is ignored.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard inputs and pipeline-register controls between the datapath and hazard_ctrl
interface hazard_ctrl_if #(
  parameter int REGW = 4
);
  logic [REGW-1:0] idRegOp1;
  logic [REGW-1:0] idRegOp2;
  logic            idUsesOp1;
  logic            idUsesOp2;
  logic [REGW-1:0] exRegDst;
  logic            exMemRead;
  logic            exWB;
  logic            exMulDiv;
  logic            branchTaken;
  logic            pcWrite;
  logic            ifIdWrite;
  logic            ifIdFlush;
  logic            idExBubble;
  logic            exHold;
  logic            exMemBubble;
  logic            state;
  logic [15:0]     stallCount;

  modport master (
    output idRegOp1, idRegOp2, idUsesOp1, idUsesOp2, exRegDst,
           exMemRead, exWB, exMulDiv, branchTaken,
    input  pcWrite, ifIdWrite, ifIdFlush, idExBubble, exHold,
           exMemBubble, state, stallCount
  );

  modport slave (
    input  idRegOp1, idRegOp2, idUsesOp1, idUsesOp2, exRegDst,
           exMemRead, exWB, exMulDiv, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, idExBubble, exHold,
           exMemBubble, state, stallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for the five-stage pipeline with mul/div hold FSM and stall counter
module hazard_ctrl #(
  parameter int REGW      = 4,
  parameter int MC_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_e;

  localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  mc_cnt_q, mc_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic [REGW-1:0] op1, op2, dst;
  logic load_use;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble;

  assign op1 = hz.idRegOp1;
  assign op2 = hz.idRegOp2;
  assign dst = hz.exRegDst;

  assign load_use = hz.exMemRead & hz.exWB &
                    ((hz.idUsesOp1 & (op1 == dst)) | (hz.idUsesOp2 & (op2 == dst)));

  always_comb begin
    state_d       = state_q;
    mc_cnt_d      = mc_cnt_q;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_hold       = 1'b0;
    ex_mem_bubble = 1'b0;

    if (!rst) begin
      // Reset flushes the whole front end and aborts any mul/div in flight.
      state_d       = RUN;
      mc_cnt_d      = 4'd0;
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.branchTaken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hz.exMulDiv) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = MC_BUSY;
            mc_cnt_d      = MC_LOAD;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MC_BUSY: begin
          if (mc_cnt_q != 4'd0) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_hold       = 1'b1;
            ex_mem_bubble = 1'b1;
            mc_cnt_d      = mc_cnt_q - 4'd1;
          end else begin
            // Release cycle: the result drains into EX/MEM while fetch resumes.
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (!rst) begin
      stall_cnt_d = 16'd0;
    end else if (!pc_write && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    mc_cnt_q    <= mc_cnt_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign hz.pcWrite     = pc_write;
  assign hz.ifIdWrite   = if_id_write;
  assign hz.ifIdFlush   = if_id_flush;
  assign hz.idExBubble  = id_ex_bubble;
  assign hz.exHold      = ex_hold;
  assign hz.exMemBubble = ex_mem_bubble;
  assign hz.state       = state_q;
  assign hz.stallCount  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with MC_CYCLES=4 and MC_CYCLES=1 instances
module tb_hazard_ctrl;

  // ctrl packing: {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exHold, exMemBubble}
  localparam logic [5:0] C_IDLE = 6'b110000;
  localparam logic [5:0] C_RST  = 6'b001101;
  localparam logic [5:0] C_LU   = 6'b000100;
  localparam logic [5:0] C_MCB  = 6'b000011;
  localparam logic [5:0] C_REL  = 6'b110000;
  localparam logic [5:0] C_BR   = 6'b111100;

  typedef struct {
    logic [5:0]  ctrl;
    logic        st;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst4 = 1'b0;
  logic rst1 = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   seq = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  hazard_ctrl_if #(.REGW(4)) if4 ();
  hazard_ctrl_if #(.REGW(4)) if1 ();

  hazard_ctrl #(.REGW(4), .MC_CYCLES(4)) dut4 (.clk(clk), .rst(rst4), .hz(if4.slave));
  hazard_ctrl #(.REGW(4), .MC_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .hz(if1.slave));

  task automatic cyc(input bit sel, input bit r,
                     input logic [3:0] op1, input logic [3:0] op2,
                     input bit u1, input bit u2, input logic [3:0] dst,
                     input bit mr, input bit wb, input bit md, input bit br,
                     input logic [5:0] ec, input bit es, input logic [15:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel == 1'b0) begin
      rst4 = r;
      if4.idRegOp1 = op1; if4.idRegOp2 = op2;
      if4.idUsesOp1 = u1; if4.idUsesOp2 = u2;
      if4.exRegDst = dst; if4.exMemRead = mr; if4.exWB = wb;
      if4.exMulDiv = md; if4.branchTaken = br;
    end else begin
      rst1 = r;
      if1.idRegOp1 = op1; if1.idRegOp2 = op2;
      if1.idUsesOp1 = u1; if1.idUsesOp2 = u2;
      if1.exRegDst = dst; if1.exMemRead = mr; if1.exWB = wb;
      if1.exMulDiv = md; if1.branchTaken = br;
    end
    e.ctrl = ec; e.st = es; e.cnt = ecnt; e.idx = seq;
    seq++;
    if (sel == 1'b0) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic idle(input bit sel, input logic [5:0] ec, input bit es, input logic [15:0] ecnt);
    cyc(sel, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, ecnt);
  endtask

  task automatic check(input string tag, input exp_t e, input logic [5:0] ac,
                       input logic ast, input logic [15:0] acnt);
    n_cmp++;
    if (ac !== e.ctrl) begin
      n_bad++;
      $display("FAIL %s#%0d ctrl: got %b want %b", tag, e.idx, ac, e.ctrl);
    end
    n_cmp++;
    if (ast !== e.st) begin
      n_bad++;
      $display("FAIL %s#%0d state: got %b want %b", tag, e.idx, ast, e.st);
    end
    n_cmp++;
    if (acnt !== e.cnt) begin
      n_bad++;
      $display("FAIL %s#%0d stallCount: got %0d want %0d", tag, e.idx, acnt, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check("mc4", e, {if4.pcWrite, if4.ifIdWrite, if4.ifIdFlush, if4.idExBubble,
                       if4.exHold, if4.exMemBubble}, if4.state, if4.stallCount);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("mc1", e, {if1.pcWrite, if1.ifIdWrite, if1.ifIdFlush, if1.idExBubble,
                       if1.exHold, if1.exMemBubble}, if1.state, if1.stallCount);
    end
  end

  initial begin
    if4.idRegOp1 = 0; if4.idRegOp2 = 0; if4.idUsesOp1 = 0; if4.idUsesOp2 = 0;
    if4.exRegDst = 0; if4.exMemRead = 0; if4.exWB = 0; if4.exMulDiv = 0; if4.branchTaken = 0;
    if1.idRegOp1 = 0; if1.idRegOp2 = 0; if1.idUsesOp1 = 0; if1.idUsesOp2 = 0;
    if1.exRegDst = 0; if1.exMemRead = 0; if1.exWB = 0; if1.exMulDiv = 0; if1.branchTaken = 0;

    // reset two cycles, then idle
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
    idle(0, C_IDLE, 0, 0);

    // load-use on op2: one stall cycle
    cyc(0, 1, 4'd1, 4'd5, 0, 1, 4'd5, 1, 1, 0, 0, C_LU, 0, 0);
    idle(0, C_IDLE, 0, 1);
    // no use of op2, or no writeback: no stall
    cyc(0, 1, 4'd1, 4'd5, 0, 0, 4'd5, 1, 1, 0, 0, C_IDLE, 0, 1);
    cyc(0, 1, 4'd1, 4'd5, 0, 1, 4'd5, 1, 0, 0, 0, C_IDLE, 0, 1);
    // match on op1, then on register 0
    cyc(0, 1, 4'd9, 4'd2, 1, 0, 4'd9, 1, 1, 0, 0, C_LU, 0, 1);
    cyc(0, 1, 4'd0, 4'd3, 1, 1, 4'd0, 1, 1, 0, 0, C_LU, 0, 2);
    idle(0, C_IDLE, 0, 3);

    // mul/div: four stall cycles then release; branch+loadUse ignored mid-op
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MCB, 0, 3);
    idle(0, C_MCB, 1, 4);
    cyc(0, 1, 4'd7, 4'd0, 1, 0, 4'd7, 1, 1, 1, 1, C_MCB, 1, 5);
    idle(0, C_MCB, 1, 6);
    idle(0, C_REL, 1, 7);
    idle(0, C_IDLE, 0, 7);

    // branch beats simultaneous mul/div and load-use
    cyc(0, 1, 4'd4, 4'd0, 1, 0, 4'd4, 1, 1, 1, 1, C_BR, 0, 7);
    idle(0, C_IDLE, 0, 7);

    // reset aborts mul/div with no release cycle
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MCB, 0, 7);
    idle(0, C_MCB, 1, 8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 1, 9);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
    idle(0, C_IDLE, 0, 0);
    cyc(0, 1, 4'd2, 4'd6, 1, 1, 4'd6, 1, 1, 0, 0, C_LU, 0, 0);
    idle(0, C_IDLE, 0, 1);

    // MC_CYCLES=1 instance: single stall, release ignores a second pulse
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0);
    idle(1, C_IDLE, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_MCB, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_REL, 1, 1);
    idle(1, C_IDLE, 0, 1);
    idle(1, C_IDLE, 0, 1);

    for (int i = 0; i < 10 && (q4.size() > 0 || q1.size() > 0); i++) @(posedge clk);
    if (q4.size() > 0 || q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q4.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
